rotate_seq_ctrl: RTL

Sequencer that drives an external rotate_reg: accepts a (data, amount) request, pulses the register's load, then issues exactly the required number of single-bit rotate pulses. It returns the register contents on a valid/ready response channel. It sits between a requesting master and one rotate_reg instance, so no requester ever toggles ld/sh directly.

---
 rtl/rotate_seq_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rotate_seq_ctrl.sv
// rtl/rotate_seq_ctrl.sv - load/shift sequencer for an external rotate_reg
//
// Purpose:
//   Accepts a (data, amount) request. Pulses the attached register's load with
//   the data, then issues one single-bit rotate pulse per unit of the effective
//   amount. The register contents are returned on a valid/ready response
//   channel. Requesters never drive the register's ld/sh directly.
//
// Optional feature (macro ROT_MOD_EN):
//   defined   - effective amount = req_amt mod bit_width (low-bit mask).
//               bit_width must be a power of two and 2**amt_width >= bit_width.
//   undefined - effective amount = req_amt, so full wraps are pulsed out.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  controller can accept a request (IDLE only)
//   req_data   in   value to load into the register
//   req_amt    in   number of single-bit rotations
//   reg_ld     out  rotate_reg load strobe
//   reg_sh     out  rotate_reg single-bit rotate strobe
//   reg_din    out  rotate_reg data_in (hold register)
//   reg_dout   in   rotate_reg data_out
//   rsp_valid  out  result available (RESP only)
//   rsp_ready  in   consumer takes result
//   rsp_data   out  rotated result, zero outside RESP
//   busy       out  high in any state other than IDLE

module rotate_seq_ctrl #(
  parameter int bit_width = 8,
  parameter int amt_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [bit_width-1:0] req_data,
  input  logic [amt_width-1:0] req_amt,
  output logic                 reg_ld,
  output logic                 reg_sh,
  output logic [bit_width-1:0] reg_din,
  input  logic [bit_width-1:0] reg_dout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [bit_width-1:0] rsp_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [amt_width-1:0] cnt_q,   cnt_d;
  logic [bit_width-1:0] hold_q,  hold_d;
  logic [amt_width-1:0] eff_amt;

`ifdef ROT_MOD_EN
  // The modulo is a plain mask, so it only works for power-of-two widths
  // whose index fits in the amount field.
  if (((bit_width & (bit_width - 1)) != 0) || (bit_width > (1 << amt_width))) begin : g_mod_check
    $error("rotate_seq_ctrl: ROT_MOD_EN needs power-of-two bit_width and 2**amt_width >= bit_width");
  end

  localparam logic [amt_width-1:0] MOD_MASK = amt_width'(bit_width - 1);

  assign eff_amt = req_amt & MOD_MASK;
`else
  assign eff_amt = req_amt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          hold_d  = req_data;
          cnt_d   = eff_amt;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = (cnt_q == '0) ? RESP : SHIFT;
      end
      SHIFT: begin
        // The counter holds the pulses still to issue including this one,
        // so a value of 1 means this is the final sh cycle.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == amt_width'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state register so an asynchronous reset
  // drops them without waiting for a clock edge.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    reg_ld    = (state_q == LOAD);
    reg_sh    = (state_q == SHIFT);
    rsp_valid = (state_q == RESP);
    reg_din   = hold_q;
    rsp_data  = (state_q == RESP) ? reg_dout : '0;
  end

endmodule
